pps_timebase: RTL and testbench

Parametrised PPS discipline block, successor to the single-input gps PPS sync/out path in the board top-levels. Selects one of NCHAN external PPS inputs, synchronises and qualifies it, and drives a flywheel second counter. The flywheel's 1-cycle tick and stretched pps_out stay phase-aligned to the selected input, with lock and holdover status. Sits between board pins and the timeservice/LED logic in mkFTop-level designs.

---
 rtl/pps_timebase.sv | 198 +++++++++++++++++++
 tb/tb_pps_timebase.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pps_timebase.sv
// PPS discipline: selects one of NCHAN PPS pins, qualifies its edges and keeps a
// flywheel second counter phase-aligned to it, with lock/holdover status.
module pps_timebase #(
  parameter int NCHAN    = 2,
  parameter int SEL_W    = 1,
  parameter int CNT_W    = 28,
  parameter int NOMINAL  = 125000000,
  parameter int TOL      = 1000,
  parameter int LOCK_N   = 3,
  parameter int MISS_N   = 2,
  parameter int HOLD_MAX = 60,
  parameter int PULSE_W  = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [NCHAN-1:0] pps_in,
  input  logic [SEL_W-1:0] sel,
  input  logic [1:0]       mode,
  output logic             pps_tick,
  output logic             pps_out,
  output logic             locked,
  output logic             holdover,
  output logic [CNT_W-1:0] last_period,
  output logic [2:0]       led
);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_ACQUIRE,
    ST_LOCKED,
    ST_HOLDOVER
  } state_t;

  localparam int W1 = CNT_W + 1;

  localparam logic [CNT_W-1:0] PH_LAST     = CNT_W'(NOMINAL - 1);
  localparam logic [CNT_W-1:0] PH_EARLY_LO = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0] PH_EARLY_HI = CNT_W'(NOMINAL - 2);
  localparam logic [CNT_W-1:0] PH_TOL      = CNT_W'(TOL);
  localparam logic [W1-1:0]    IV_LO       = W1'(NOMINAL - TOL);
  localparam logic [W1-1:0]    IV_HI       = W1'(NOMINAL + TOL);
  localparam logic [CNT_W-1:0] LOCK_C      = CNT_W'(LOCK_N);
  localparam logic [CNT_W-1:0] MISS_C      = CNT_W'(MISS_N);
  localparam logic [CNT_W-1:0] HOLD_C      = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] PULSE_C     = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] IV_MAX      = '1;

  state_t           state;
  logic [NCHAN-1:0] sync1, sync2;
  logic             edge_d;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] ph, iv, good_cnt, miss_cnt, hold_cnt, str_cnt;
  logic             iv_valid, seen;

  logic             sel_bit, e, sel_chg, good, in_win, early, late, wrap;
  logic [W1-1:0]    iv_p1;

  // Out-of-range select values leave sel_bit low, so no edges are seen.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (sel == SEL_W'(i)) sel_bit = sync2[i];
    end
  end

  assign e       = sel_bit & ~edge_d;
  assign sel_chg = (sel != sel_q);
  assign iv_p1   = {1'b0, iv} + W1'(1);
  assign good    = e && iv_valid && (iv_p1 >= IV_LO) && (iv_p1 <= IV_HI);
  assign in_win  = (ph >= PH_EARLY_LO) || (ph <= PH_TOL);
  assign early   = (ph >= PH_EARLY_LO) && (ph <= PH_EARLY_HI);
  assign late    = (ph <= PH_TOL);
  assign wrap    = (ph == PH_LAST);

  assign locked   = (state == ST_LOCKED);
  assign holdover = (state == ST_HOLDOVER);
  assign led      = {locked, holdover, pps_out};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= ST_FREE;
      sync1       <= '0;
      sync2       <= '0;
      edge_d      <= 1'b0;
      sel_q       <= sel;
      ph          <= '0;
      iv          <= '0;
      iv_valid    <= 1'b0;
      good_cnt    <= '0;
      miss_cnt    <= '0;
      hold_cnt    <= '0;
      str_cnt     <= '0;
      seen        <= 1'b0;
      pps_tick    <= 1'b0;
      pps_out     <= 1'b0;
      last_period <= '0;
    end else begin
      sync1  <= pps_in;
      sync2  <= sync1;
      edge_d <= sel_bit;
      sel_q  <= sel;

      if (e && !sel_chg) begin
        if (iv_valid) last_period <= (iv == IV_MAX) ? IV_MAX : iv_p1[CNT_W-1:0];
        iv       <= '0;
        iv_valid <= 1'b1;
      end else begin
        if (iv != IV_MAX) iv <= iv + ONE;
        if (sel_chg) iv_valid <= 1'b0;
      end

      ph       <= wrap ? '0 : ph + ONE;
      pps_tick <= wrap;

      if (mode != 2'd1) begin
        state    <= ST_FREE;
        good_cnt <= '0;
      end else if (sel_chg) begin
        state    <= ST_ACQUIRE;
        good_cnt <= '0;
      end else begin
        case (state)
          ST_FREE: begin
            state    <= ST_ACQUIRE;
            good_cnt <= '0;
          end
          ST_ACQUIRE: begin
            if (e) begin
              if (good) begin
                ph       <= '0;
                pps_tick <= 1'b1;
                good_cnt <= good_cnt + ONE;
                if (good_cnt + ONE >= LOCK_C) begin
                  state    <= ST_LOCKED;
                  miss_cnt <= '0;
                  seen     <= 1'b1;
                end
              end else begin
                good_cnt <= '0;
              end
            end
          end
          // Late edges realign silently so a second never carries two ticks.
          ST_LOCKED: begin
            if (e && in_win) begin
              miss_cnt <= '0;
              seen     <= 1'b1;
              if (early) begin
                ph       <= '0;
                pps_tick <= 1'b1;
              end else if (late) begin
                ph <= '0;
              end
            end else begin
              if (e || (ph == PH_TOL && !seen)) begin
                miss_cnt <= miss_cnt + ONE;
                if (miss_cnt + ONE >= MISS_C) begin
                  state    <= ST_HOLDOVER;
                  hold_cnt <= '0;
                  good_cnt <= '0;
                end
              end
              if (ph == PH_TOL) seen <= 1'b0;
            end
          end
          ST_HOLDOVER: begin
            if (wrap) begin
              hold_cnt <= hold_cnt + ONE;
              if (hold_cnt + ONE >= HOLD_C) begin
                state    <= ST_ACQUIRE;
                good_cnt <= '0;
              end
            end
            if (e) begin
              if (good && in_win) begin
                good_cnt <= good_cnt + ONE;
                if (good_cnt + ONE >= LOCK_C) begin
                  state    <= ST_LOCKED;
                  miss_cnt <= '0;
                  seen     <= 1'b1;
                end
              end else begin
                good_cnt <= '0;
              end
            end
          end
          default: state <= ST_FREE;
        endcase
      end

      if (pps_tick) str_cnt <= PULSE_C;
      else if (str_cnt != '0) str_cnt <= str_cnt - ONE;
      pps_out <= (pps_tick || (str_cnt > ONE)) && !mode[1];
    end
  end

endmodule

// File: tb/tb_pps_timebase.sv
// Self-checking bench for pps_timebase: randomized pin timing, expectations derived
// from pin-rise times and the second/window rules with plain cycle arithmetic.
module tb_pps_timebase;

  localparam int NOMINAL  = 1000;
  localparam int TOL      = 10;
  localparam int HOLD_MAX = 4;
  localparam int PULSE_W  = 4;
  localparam int LAT      = 3;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [1:0]  pps_in;
  logic [0:0]  sel;
  logic [1:0]  mode;
  logic        pps_tick, pps_out, locked, holdover;
  logic [27:0] last_period;
  logic [2:0]  led;

  int cyc = 0;
  int out_hi = 0;
  int tick_log[$];
  int checks = 0;
  int fails = 0;

  pps_timebase #(
    .NCHAN(2), .SEL_W(1), .CNT_W(28), .NOMINAL(NOMINAL), .TOL(TOL),
    .LOCK_N(3), .MISS_N(2), .HOLD_MAX(HOLD_MAX), .PULSE_W(PULSE_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .pps_in(pps_in), .sel(sel), .mode(mode),
    .pps_tick(pps_tick), .pps_out(pps_out), .locked(locked),
    .holdover(holdover), .last_period(last_period), .led(led)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (pps_tick) tick_log.push_back(cyc);
    if (pps_out) out_hi <= out_hi + 1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int ticks_in(input int lo, input int hi);
    int n = 0;
    foreach (tick_log[i]) if (tick_log[i] >= lo && tick_log[i] <= hi) n++;
    return n;
  endfunction

  task automatic go_to(input int t);
    while (cyc < t) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input int ch, input int t);
    go_to(t);
    pps_in[ch] = 1'b1;
    go_to(t + 2);
    pps_in[ch] = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        fails++;
        $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
  endtask

  initial begin
    int r0, p, a, d, iv_bad, tl, q0, s0, o0, r2;
    int r[8];
    int q[4];
    int s[4];

    RST_N  = 1'b0;
    pps_in = 2'b00;
    sel    = 1'b0;
    mode   = 2'd0;
    repeat (3) begin
      @(negedge CLK);
      #1;
    end
    checkOutput("rst_tick", 32'(pps_tick), 0);
    checkOutput("rst_out", 32'(pps_out), 0);
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_led", 32'(led), 0);
    RST_N = 1'b1;
    r0 = cyc;
    o0 = out_hi;

    // Free-running flywheel: a tick every NOMINAL cycles after reset.
    go_to(r0 + 2100);
    checkOutput("free_tick1", ticks_in(r0 + NOMINAL, r0 + NOMINAL), 1);
    checkOutput("free_tick2", ticks_in(r0 + 2 * NOMINAL, r0 + 2 * NOMINAL), 1);
    checkOutput("free_tick_count", ticks_in(r0 + 1, r0 + 2100), 2);
    checkOutput("free_out_cycles", out_hi - o0, 2 * PULSE_W);
    checkOutput("free_locked", 32'(locked), 0);
    checkOutput("free_last_period", 32'(last_period), 0);

    // Acquire on clean seconds starting at a random phase.
    mode = 2'd1;
    p = int'($urandom_range(800, 200));
    for (int k = 0; k < 4; k++) r[k] = cyc + p + k * NOMINAL;
    for (int k = 0; k < 3; k++) applyStimulus(0, r[k]);
    applyStimulus(0, r[3]);
    checkOutput("acq_before_lock", 32'(locked), 0);
    go_to(r[3] + LAT);
    checkOutput("acq_locked", 32'(locked), 1);
    checkOutput("acq_tick_edge1", ticks_in(r[1] + LAT, r[1] + LAT), 1);
    checkOutput("acq_tick_count", ticks_in(r[1] + LAT, r[3] + LAT), 3);
    checkOutput("acq_last_period", 32'(last_period), NOMINAL);

    // Locked: one clean, one early, one late (relative to flywheel), one clean.
    a = int'($urandom_range(9, 1));
    d = int'($urandom_range(11, 2));
    r[4] = r[3] + NOMINAL;
    r[5] = r[4] + NOMINAL - a;
    r[6] = r[5] + NOMINAL + d;
    r[7] = r[6] + NOMINAL;
    applyStimulus(0, r[4]);
    go_to(r[4] + LAT);
    checkOutput("lock_clean_tick", ticks_in(r[4] + LAT, r[4] + LAT), 1);
    applyStimulus(0, r[5]);
    go_to(r[5] + LAT);
    checkOutput("early_tick", ticks_in(r[5] + LAT, r[5] + LAT), 1);
    checkOutput("early_no_wrap", ticks_in(r[4] + LAT + 1, r[5] + LAT - 1), 0);
    checkOutput("early_period", 32'(last_period), NOMINAL - a);
    applyStimulus(0, r[6]);
    go_to(r[6] + LAT);
    checkOutput("late_period", 32'(last_period), NOMINAL + d);
    applyStimulus(0, r[7]);
    go_to(r[7] + LAT);
    checkOutput("late_natural_tick", ticks_in(r[5] + LAT + NOMINAL, r[5] + LAT + NOMINAL), 1);
    checkOutput("late_no_extra", ticks_in(r[5] + LAT + NOMINAL + 1, r[7] + LAT - 1), 0);
    checkOutput("late_realigned", ticks_in(r[7] + LAT, r[7] + LAT), 1);
    checkOutput("late_still_locked", 32'(locked), 1);

    // Input stops: two missed seconds to holdover, HOLD_MAX ticks back to acquire.
    tl = r[7];
    go_to(tl + 1500);
    checkOutput("miss1_locked", 32'(locked), 1);
    checkOutput("miss1_holdover", 32'(holdover), 0);
    go_to(tl + 2500);
    checkOutput("hold_flag", 32'(holdover), 1);
    checkOutput("hold_led", 32'(led), 2);
    go_to(tl + LAT + HOLD_MAX * NOMINAL + 1500 - NOMINAL);
    checkOutput("hold_still", 32'(holdover), 1);
    go_to(tl + 6500);
    checkOutput("hold_exit_holdover", 32'(holdover), 0);
    checkOutput("hold_exit_locked", 32'(locked), 0);
    checkOutput("hold_tick_count", ticks_in(tl + LAT, tl + 6500), 7);

    // Off-nominal interval never qualifies.
    iv_bad = int'($urandom_range(1100, 1015));
    q0 = cyc + 100;
    for (int k = 0; k < 4; k++) begin
      q[k] = q0 + k * iv_bad;
      applyStimulus(0, q[k]);
      if (k > 0) begin
        go_to(q[k] + LAT);
        checkOutput("bad_period", 32'(last_period), iv_bad);
        checkOutput("bad_unlocked", 32'(locked), 0);
      end
    end

    // Switch to channel 1 carrying clean seconds.
    go_to(q[3] + 200);
    sel = 1'b1;
    s0 = cyc + 100 + int'($urandom_range(500, 0));
    for (int k = 0; k < 4; k++) s[k] = s0 + k * NOMINAL;
    for (int k = 0; k < 4; k++) applyStimulus(1, s[k]);
    checkOutput("ch1_before_lock", 32'(locked), 0);
    go_to(s[3] + LAT);
    checkOutput("ch1_locked", 32'(locked), 1);
    checkOutput("ch1_tick", ticks_in(s[3] + LAT, s[3] + LAT), 1);
    checkOutput("ch1_period", 32'(last_period), NOMINAL);

    // Reset in the middle of a stretched pulse, then output-disabled mode.
    go_to(s[3] + LAT + NOMINAL + 2);
    checkOutput("pulse_mid", 32'(pps_out), 1);
    RST_N = 1'b0;
    go_to(s[3] + LAT + NOMINAL + 3);
    checkOutput("rst2_out", 32'(pps_out), 0);
    checkOutput("rst2_locked", 32'(locked), 0);
    checkOutput("rst2_period", 32'(last_period), 0);
    checkOutput("rst2_led", 32'(led), 0);
    mode  = 2'd2;
    RST_N = 1'b1;
    r2 = cyc;
    o0 = out_hi;
    go_to(r2 + 1100);
    checkOutput("dis_tick", ticks_in(r2 + NOMINAL, r2 + NOMINAL), 1);
    checkOutput("dis_out_cycles", out_hi - o0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
